// File: rtl/gmsk_tx_sequencer.sv
// Burst sequencer for a GMSK modulator: derives sample/symbol strobes, pulls one
// data bit per symbol from upstream, then pads with zero fill symbols to drain the modulator.
module gmsk_tx_sequencer #(
    parameter int CLOCKS_PER_SAMPLE  = 4,
    parameter int SAMPLES_PER_SYMBOL = 16,
    parameter int BURST_BITS         = 148,
    parameter int FLUSH_SYMBOLS      = 3
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic bit_valid,
    input  logic bit_data,
    output logic bit_ready,
    output logic symbol_strobe,
    output logic sample_strobe,
    output logic tx_bit,
    output logic busy,
    output logic done,
    output logic underrun
);

    localparam int CW = $clog2(CLOCKS_PER_SAMPLE);
    localparam int SW = $clog2(SAMPLES_PER_SYMBOL);
    localparam int YW = $clog2(BURST_BITS + FLUSH_SYMBOLS + 1);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLOCKS_PER_SAMPLE - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [YW-1:0] DATA_END  = YW'(BURST_BITS);
    localparam logic [YW-1:0] SYM_END   = YW'(BURST_BITS + FLUSH_SYMBOLS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [SW-1:0] samp_cnt;
    logic [YW-1:0] sym_cnt;
    logic          period_end;

    assign busy          = (state != IDLE);
    assign sample_strobe = busy && (clk_cnt == CLK_LAST);
    // clk_cnt==0 here while sample_strobe needs clk_cnt==CPS-1, so the two never overlap
    assign symbol_strobe = busy && (clk_cnt == '0) && (samp_cnt == '0);
    assign period_end    = sample_strobe && (samp_cnt == SAMP_LAST);
    assign bit_ready     = (state == ACTIVE) && symbol_strobe;
    assign done          = (state == FLUSH) && period_end && (sym_cnt == SYM_END);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            samp_cnt <= '0;
            sym_cnt  <= '0;
            tx_bit   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACTIVE;
                        clk_cnt  <= '0;
                        samp_cnt <= '0;
                        sym_cnt  <= '0;
                        underrun <= 1'b0;
                    end
                end
                ACTIVE, FLUSH: begin
                    clk_cnt <= sample_strobe ? '0 : clk_cnt + CW'(1);
                    if (sample_strobe)
                        samp_cnt <= period_end ? '0 : samp_cnt + SW'(1);
                    if (symbol_strobe)
                        sym_cnt <= sym_cnt + YW'(1);

                    // a missing bit still occupies its slot so burst timing is fixed
                    if (bit_ready) begin
                        tx_bit <= bit_valid & bit_data;
                        if (!bit_valid)
                            underrun <= 1'b1;
                    end else if (state == FLUSH && symbol_strobe) begin
                        tx_bit <= 1'b0;
                    end

                    if (state == ACTIVE && period_end && sym_cnt == DATA_END)
                        state <= FLUSH;
                    if (done) begin
                        state    <= IDLE;
                        clk_cnt  <= '0;
                        samp_cnt <= '0;
                        sym_cnt  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmsk_tx_sequencer.sv
// Bench for gmsk_tx_sequencer: timeline model plus tx_bit scoreboard on a small
// configuration, and a count-based check of a full default-parameter burst.
module tb_gmsk_tx_sequencer;

    localparam int CPS = 2, SPS = 4, BB = 4, FL = 3;
    localparam int PER = CPS * SPS;
    localparam int DUR = (BB + FL) * PER;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n, start, bit_valid, bit_data;
    logic bit_ready, symbol_strobe, sample_strobe, tx_bit, busy, done, underrun;
    logic start_d, bit_valid_d, bit_data_d;
    logic bit_ready_d, symbol_strobe_d, sample_strobe_d, tx_bit_d, busy_d, done_d, underrun_d;

    gmsk_tx_sequencer #(
        .CLOCKS_PER_SAMPLE(CPS), .SAMPLES_PER_SYMBOL(SPS),
        .BURST_BITS(BB), .FLUSH_SYMBOLS(FL)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
        .symbol_strobe(symbol_strobe), .sample_strobe(sample_strobe),
        .tx_bit(tx_bit), .busy(busy), .done(done), .underrun(underrun)
    );

    gmsk_tx_sequencer dut_def (
        .clock(clock), .reset_n(reset_n), .start(start_d),
        .bit_valid(bit_valid_d), .bit_data(bit_data_d), .bit_ready(bit_ready_d),
        .symbol_strobe(symbol_strobe_d), .sample_strobe(sample_strobe_d),
        .tx_bit(tx_bit_d), .busy(busy_d), .done(done_d), .underrun(underrun_d)
    );

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference timeline: burst begins at b0, everything else is an offset from it
    int   b0 = -1;
    logic und_m = 1'b0;
    logic cur_m = 1'b0;
    logic q[$];

    always @(negedge clock) begin
        int   off;
        logic bz, sy, sa, dn, rd;
        if (mon_en) begin
            off = cyc - b0;
            bz  = (b0 >= 0) && (off >= 0) && (off < DUR);
            sy  = bz && (off % PER == 0);
            sa  = bz && (off % CPS == CPS - 1);
            dn  = bz && (off == DUR - 1);
            rd  = sy && (off < BB * PER);
            if (bz && (off % PER == 1)) begin
                chk("sb_depth", q.size(), 1);
                if (q.size() > 0) cur_m = q.pop_front();
            end
            chk("busy", busy, bz);
            chk("symbol_strobe", symbol_strobe, sy);
            chk("sample_strobe", sample_strobe, sa);
            chk("done", done, dn);
            chk("bit_ready", bit_ready, rd);
            chk("tx_bit", tx_bit, cur_m);
            chk("underrun", underrun, und_m);
            if (!reset_n) begin
                b0 = -1; und_m = 1'b0; cur_m = 1'b0; q.delete();
            end else begin
                if (rd && !bit_valid) und_m = 1'b1;
                if (sy) q.push_back(rd ? (bit_valid & bit_data) : 1'b0);
                if (dn) b0 = -1;
                else if (!bz && start) begin
                    b0 = cyc + 1; und_m = 1'b0;
                end
            end
        end
    end

    int busy_n = 0, ready_n = 0, sym_n = 0, samp_n = 0, done_n = 0;
    always @(negedge clock) begin
        if (mon_en) begin
            busy_n  += int'(busy_d);
            ready_n += int'(bit_ready_d);
            sym_n   += int'(symbol_strobe_d);
            samp_n  += int'(sample_strobe_d);
            done_n  += int'(done_d);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // t is relative to the first start; bits/vld apply to the first burst's data symbols
    task automatic burst_test(input logic [3:0] bits, input logic [3:0] vld,
                              input int s1, input int s2, input int s3,
                              input int ra, input int total);
        for (int t = 0; t < total; t++) begin
            start   = (t == 0) || (t == s1) || (t == s2) || (t == s3);
            reset_n = (t != ra);
            if (t >= 1 && (t - 1) % PER == 0 && (t - 1) / PER < BB) begin
                bit_data  = bits[(t-1)/PER];
                bit_valid = vld[(t-1)/PER];
            end else begin
                bit_data  = 1'($urandom);
                bit_valid = 1'b1;
            end
            step();
        end
        start   = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; bit_valid = 1'b1; bit_data = 1'b0;
        start_d = 1'b0; bit_valid_d = 1'b1; bit_data_d = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        reset_n = 1'b1;
        step();
        step();

        burst_test(4'b1101, 4'b1111, -1, -1, -1, -1, 60);
        burst_test(4'b1111, 4'b1011, -1, -1, -1, -1, 60);
        burst_test(4'b0110, 4'b0111, 20, 56, 58, -1, 120);
        burst_test(4'b1010, 4'b1111, 33, -1, -1, 30, 100);

        start_d = 1'b1;
        step();
        start_d = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            bit_data_d = 1'($urandom);
            step();
            if (done_n > 0) break;
        end
        step();
        step();
        chk("def_busy_cycles", busy_n, 151 * 16 * 4);
        chk("def_bit_ready", ready_n, 148);
        chk("def_symbols", sym_n, 151);
        chk("def_samples", samp_n, 151 * 16);
        chk("def_done", done_n, 1);
        chk("def_underrun", underrun_d, 0);
        chk("def_idle", busy_d, 0);
        chk("def_tx_bit", tx_bit_d, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/gmsk_tx_sequencer.md
GMSK_TX_SEQUENCER -- requirements
Module: gmsk_tx_sequencer

Interface
REQ-001 SHALL have parameter CLOCKS_PER_SAMPLE, default 4: clocks per sample_strobe period; legal range >=2.
REQ-002 SHALL have parameter SAMPLES_PER_SYMBOL, default 16: sample_strobe pulses per symbol period; legal range >=2.
REQ-003 SHALL have parameter BURST_BITS, default 148: data symbols per burst.
REQ-004 SHALL have parameter FLUSH_SYMBOLS, default 3: fill symbols appended after data so the modulator's 3-bit history and output pipeline drain.
REQ-005 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port start, input, 1: single-cycle burst request.
REQ-008 SHALL have port bit_valid, input, 1: upstream has a data bit available.
REQ-009 SHALL have port bit_data, input, 1: upstream data bit.
REQ-010 SHALL have port bit_ready, output, 1: one-cycle pulse; bit_data is consumed when bit_ready and bit_valid are both high.
REQ-011 SHALL have port symbol_strobe, output, 1: symbol boundary pulse to the modulator.
REQ-012 SHALL have port sample_strobe, output, 1: sample advance pulse to the modulator.
REQ-013 SHALL have port tx_bit, output, 1: bit presented to the modulator input_bit.
REQ-014 SHALL have port busy, output, 1: burst in progress; also serves as the transmit enable.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at end of burst.
REQ-016 SHALL have port underrun, output, 1: sticky flag, set when a data bit was missing during the burst.

Function
REQ-017 SHALL implement states IDLE, ACTIVE and FLUSH; busy = (state != IDLE).
REQ-018 In IDLE, start=1 SHALL clear all counters and the underrun flag and enter ACTIVE on the next edge; start SHALL be ignored outside IDLE.
REQ-019 SHALL keep a clock counter clk_cnt (0..CLOCKS_PER_SAMPLE-1) and a sample counter samp_cnt (0..SAMPLES_PER_SYMBOL-1); both count only while busy and hold 0 in IDLE.
REQ-020 sample_strobe SHALL be high exactly when busy and clk_cnt == CLOCKS_PER_SAMPLE-1; samp_cnt SHALL advance on each sample_strobe and wrap to 0.
REQ-021 symbol_strobe SHALL be high exactly when busy, clk_cnt == 0 and samp_cnt == 0; it SHALL never coincide with sample_strobe.
REQ-022 The first symbol_strobe SHALL occur on the first cycle busy is high, i.e. one cycle after start is sampled.
REQ-023 In ACTIVE, bit_ready SHALL be high on every symbol_strobe cycle; it SHALL be low at all other times and in FLUSH and IDLE.
REQ-024 On an ACTIVE symbol_strobe with bit_valid=1, tx_bit SHALL take bit_data on the next edge and hold it for the whole symbol period.
REQ-025 On an ACTIVE symbol_strobe with bit_valid=0, tx_bit SHALL take 0, underrun SHALL set, and the symbol SHALL still count toward BURST_BITS; the burst SHALL NOT stall.
REQ-026 SHALL keep a symbol counter sym_cnt that increments on every symbol_strobe; its width SHALL be ceil(log2(BURST_BITS+FLUSH_SYMBOLS+1)) bits.
REQ-027 SHALL transition ACTIVE->FLUSH on the last sample_strobe of the symbol period in which sym_cnt reached BURST_BITS.
REQ-028 In FLUSH, tx_bit SHALL be 0 at each symbol_strobe.
REQ-029 SHALL transition FLUSH->IDLE on the last sample_strobe of the period in which sym_cnt reached BURST_BITS+FLUSH_SYMBOLS; done SHALL pulse on that same cycle.
REQ-030 Total busy duration SHALL be exactly (BURST_BITS+FLUSH_SYMBOLS) x SAMPLES_PER_SYMBOL x CLOCKS_PER_SAMPLE cycles.
REQ-031 underrun SHALL hold its value in IDLE until the next accepted start or reset.
REQ-032 A start arriving on the same cycle as done SHALL be ignored; the next burst requires start while in IDLE.

Reset
REQ-033 reset_n=0 on a rising edge SHALL force IDLE and clear all counters; bit_ready, symbol_strobe, sample_strobe, tx_bit, busy, done and underrun SHALL all be 0 on the following cycle.
REQ-034 Reset mid-burst SHALL abort the burst without a done pulse; consumed bits are not replayed.

Verification
REQ-035 Parameters CPS=2, SPS=4, BURST_BITS=4, FLUSH=3; start at cycle 0, bit_valid always 1 with bits 1,0,1,1 -> busy high cycles 1..56; symbol_strobe at cycles 1,9,17,...,49; tx_bit follows 1,0,1,1,0,0,0; done at cycle 56; underrun=0.
REQ-036 Same parameters, bit_valid=0 for the 3rd symbol only -> tx_bit third symbol = 0; underrun=1 after cycle 17 and still 1 in IDLE; busy duration still 56 cycles.
REQ-037 Strobe check over a burst -> sample_strobe on every even cycle while busy (28 pulses); symbol_strobe and sample_strobe never both high; 4 bit_ready pulses, each coincident with symbol_strobe.
REQ-038 start re-pulsed at cycle 20 and coincident with done -> ignored; a single burst with a single done; a start at cycle 58 launches a new burst and clears underrun.
REQ-039 reset_n low at cycle 30 -> cycle 31 all outputs 0 and no done pulse; start at cycle 33 yields a full 56-cycle burst.
REQ-040 Default parameters, full burst -> busy for 151x16x4 = 9664 cycles; exactly 148 bit_ready pulses.
